deser_24: RTL and testbench

DESER_24 -- requirements
Module: deser_24

---
 rtl/deser_24.sv | 102 ++++++++++
 tb/tb_deser_24.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/deser_24.sv
// Serial-to-parallel receiver: MSB-first bits gathered into WIDTH-bit words,
// with a one-deep output holding register, valid/ready handshake and sticky overrun.
module deser_24 #(
  parameter int unsigned WIDTH = 24
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic             Shift_In,
  input  logic             Shift_En,
  input  logic             Ready,
  output logic [WIDTH-1:0] Data_Out,
  output logic             Valid,
  output logic             Busy,
  output logic [4:0]       Bit_Count,
  output logic             Overrun
);

  typedef enum logic {IDLE, RECV} state_t;

  localparam logic [4:0] LAST = 5'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [4:0]       cnt_q, cnt_d;
  logic             valid_q, valid_d;
  logic             ovr_q, ovr_d;
  logic [1:0]       rst_sync_q;
  logic             rst;
  logic [WIDTH-1:0] word;

  // Reset asserts immediately but releases only on a clock edge.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) rst_sync_q <= '1;
    else       rst_sync_q <= {rst_sync_q[0], 1'b0};
  end
  assign rst = rst_sync_q[1];

  always_ff @(posedge Clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      shreg_q <= '0;
      data_q  <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
    end
  end

  assign word = {shreg_q[WIDTH-2:0], Shift_In};

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    ovr_d   = ovr_q;
    // A handshake frees the holding register before any same-edge completion.
    valid_d = valid_q && !Ready;

    if (Start) begin
      state_d = RECV;
      ovr_d   = 1'b0;
      if (Shift_En) begin
        shreg_d = WIDTH'(Shift_In);
        cnt_d   = 5'd1;
      end else begin
        shreg_d = '0;
        cnt_d   = '0;
      end
    end else if (state_q == RECV && Shift_En) begin
      shreg_d = word;
      if (cnt_q == LAST) begin
        state_d = IDLE;
        cnt_d   = '0;
        if (valid_d) begin
          ovr_d = 1'b1;
        end else begin
          data_d  = word;
          valid_d = 1'b1;
        end
      end else begin
        cnt_d = cnt_q + 5'd1;
      end
    end
  end

  assign Data_Out  = data_q;
  assign Valid     = valid_q;
  assign Busy      = (state_q == RECV);
  assign Bit_Count = cnt_q;
  assign Overrun   = ovr_q;

endmodule

// File: tb/tb_deser_24.sv
// Directed and randomized checks of deser_24 against a word-level reference model.
module tb_deser_24;

  logic        Clk = 1'b0;
  logic        Reset = 1'b0;
  logic        Start = 1'b0;
  logic        Shift_In = 1'b0;
  logic        Shift_En = 1'b0;
  logic        Ready = 1'b0;
  logic [23:0] Data_Out;
  logic        Valid;
  logic        Busy;
  logic [4:0]  Bit_Count;
  logic        Overrun;

  int checks = 0;
  int failures = 0;

  // Reference model state: frame in progress, bits so far, accumulated value, output register.
  bit          m_busy;
  int unsigned m_n;
  int unsigned m_acc;
  int unsigned m_data;
  bit          m_valid;
  bit          m_ovr;

  deser_24 #(.WIDTH(24)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Shift_In(Shift_In),
    .Shift_En(Shift_En), .Ready(Ready), .Data_Out(Data_Out), .Valid(Valid),
    .Busy(Busy), .Bit_Count(Bit_Count), .Overrun(Overrun)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_n = 0; m_acc = 0; m_data = 0; m_valid = 0; m_ovr = 0;
  endtask

  task automatic model_step(input bit st, input bit bi, input bit en, input bit rd);
    if (m_valid && rd) m_valid = 0;
    if (st) begin
      m_busy = 1;
      m_ovr  = 0;
      m_n    = en ? 1 : 0;
      m_acc  = en ? 32'(bi) : 0;
    end else if (m_busy && en) begin
      m_acc = (m_acc * 2 + 32'(bi)) % (1 << 24);
      m_n++;
      if (m_n == 24) begin
        m_busy = 0;
        m_n    = 0;
        if (m_valid) m_ovr = 1;
        else begin m_data = m_acc; m_valid = 1; end
      end
    end
  endtask

  task automatic compare_all();
    check("valid", 32'(Valid), 32'(m_valid));
    check("data", 32'(Data_Out), m_data);
    check("busy", 32'(Busy), 32'(m_busy));
    check("bitcount", 32'(Bit_Count), m_n);
    check("overrun", 32'(Overrun), 32'(m_ovr));
  endtask

  task automatic step(input bit st, input bit bi, input bit en, input bit rd);
    @(negedge Clk);
    Start = st; Shift_In = bi; Shift_En = en; Ready = rd;
    @(posedge Clk);
    model_step(st, bi, en, rd);
    #1;
    compare_all();
  endtask

  // Start cycle, then 24 bits MSB first with (gap) idle cycles between strobes.
  task automatic frame(input logic [23:0] w, input int gap, input bit last_ready);
    logic [23:0] v;
    v = w;
    step(1, 0, 0, 0);
    for (int i = 23; i >= 0; i--) begin
      for (int g = 0; g < gap; g++) step(0, 0, 0, 0);
      step(0, v[i], 1, (i == 0) ? last_ready : 1'b0);
    end
  endtask

  initial begin
    model_reset();
    #2 Reset = 1'b1;
    #1;
    check("reset_valid", 32'(Valid), 0);
    check("reset_data", 32'(Data_Out), 0);
    check("reset_busy", 32'(Busy), 0);
    check("reset_cnt", 32'(Bit_Count), 0);
    check("reset_ovr", 32'(Overrun), 0);
    repeat (2) @(posedge Clk);
    @(negedge Clk) Reset = 1'b0;
    repeat (3) step(0, 0, 0, 0);

    // Shift_En in IDLE without Start is ignored
    repeat (4) step(0, 1, 1, 0);

    // Basic frame
    frame(24'hA5C3F0, 0, 0);
    check("basic_data", 32'(Data_Out), 32'hA5C3F0);
    check("basic_valid", 32'(Valid), 1);
    check("basic_busy", 32'(Busy), 0);
    check("basic_cnt", 32'(Bit_Count), 0);

    // Gapped strobes, hold, then handshake
    step(0, 0, 0, 1);
    frame(24'hA5C3F0, 2, 0);
    repeat (5) step(0, 0, 0, 0);
    check("gap_hold_valid", 32'(Valid), 1);
    check("gap_hold_data", 32'(Data_Out), 32'hA5C3F0);
    step(0, 0, 0, 1);
    check("gap_after_ready", 32'(Valid), 0);
    step(0, 0, 0, 1);

    // Overrun
    frame(24'h123456, 0, 0);
    frame(24'hFFFFFF, 0, 0);
    check("ovr_data", 32'(Data_Out), 32'h123456);
    check("ovr_flag", 32'(Overrun), 1);
    step(1, 0, 0, 0);
    check("ovr_cleared", 32'(Overrun), 0);

    // Completion coincident with handshake
    step(0, 0, 0, 1);
    frame(24'hABCDEF, 0, 0);
    frame(24'h000001, 0, 1);
    check("coinc_data", 32'(Data_Out), 32'h000001);
    check("coinc_valid", 32'(Valid), 1);
    check("coinc_ovr", 32'(Overrun), 0);

    // Restart after 10 bits
    step(0, 0, 0, 1);
    step(1, 1, 1, 0);
    repeat (9) step(0, 1, 1, 0);
    frame(24'h800000, 0, 0);
    check("restart_data", 32'(Data_Out), 32'h800000);

    // Start on the completion cycle takes priority
    step(0, 0, 0, 1);
    step(1, 0, 0, 0);
    repeat (23) step(0, 1, 1, 0);
    step(1, 1, 1, 0);
    check("startprio_valid", 32'(Valid), 0);
    check("startprio_cnt", 32'(Bit_Count), 1);

    // Reset mid-frame with a word pending
    frame(24'h5A5A5A, 0, 0);
    step(1, 0, 0, 0);
    repeat (12) step(0, 1, 1, 0);
    @(negedge Clk) Reset = 1'b1;
    #1;
    model_reset();
    check("midrst_valid", 32'(Valid), 0);
    check("midrst_data", 32'(Data_Out), 0);
    check("midrst_busy", 32'(Busy), 0);
    check("midrst_cnt", 32'(Bit_Count), 0);
    check("midrst_ovr", 32'(Overrun), 0);
    repeat (2) @(posedge Clk);
    @(negedge Clk) Reset = 1'b0;
    repeat (3) step(0, 0, 0, 0);
    repeat (12) step(0, 1, 1, 0);
    check("postrst_valid", 32'(Valid), 0);

    // Randomized traffic against the model
    for (int i = 0; i < 4000; i++) begin
      step(($urandom_range(0, 39) == 0), 1'($urandom),
           ($urandom_range(0, 9) < 7), ($urandom_range(0, 9) < 2));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
